// File: rtl/pc_pkg.sv
// ============================================================================
// Module      : pc_pkg
// Description : Shared types and helpers for the fetch-PC controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        RD_NONE   = 2'd0,
        RD_BRANCH = 2'd1,
        RD_JUMP   = 2'd2,
        RD_TRAP   = 2'd3
    } redirect_e;

    localparam int c_MAX_ALIGN_LSBS = 2;

    // Number of low address bits that must be zero for an IALIGN-aligned target.
    function automatic int align_lsbs(input int ialign);
        return (ialign >= 4) ? c_MAX_ALIGN_LSBS : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pc_target_calc.sv
// ============================================================================
// Module      : pc_target_calc
// Description : Redirect target, priority cause and alignment check.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_target_calc
    import pc_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int IALIGN = 4
) (
    input  logic            branch_en,
    input  logic            take_branch,
    input  logic            jump_en,
    input  logic            jalr,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] imm,
    input  logic            trap_en,
    input  logic [XLEN-1:0] trap_vector,
    output logic [XLEN-1:0] target,
    output redirect_e       cause,
    output logic            misaligned
);

    localparam logic [XLEN-1:0] c_ALIGN_MASK = XLEN'((1 << align_lsbs(IALIGN)) - 1);

    logic [XLEN-1:0] w_sum;
    logic [XLEN-1:0] w_jt;

    always_comb begin
        w_sum      = (jalr ? rs1 : ex_pc) + imm;
        w_jt       = jalr ? {w_sum[XLEN-1:1], 1'b0} : w_sum;
        target     = w_jt;
        cause      = RD_NONE;
        misaligned = 1'b0;
        if (trap_en) begin
            target = trap_vector;
            cause  = RD_TRAP;
        end else if (jump_en) begin
            cause      = RD_JUMP;
            misaligned = |(w_jt & c_ALIGN_MASK);
        end else if (branch_en && take_branch) begin
            cause      = RD_BRANCH;
            misaligned = |(w_jt & c_ALIGN_MASK);
        end
    end

endmodule

`default_nettype wire

// File: rtl/pc_fetch_ctrl.sv
// ============================================================================
// Module      : pc_fetch_ctrl
// Description : Fetch PC owner with imem handshake and redirect handling.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_fetch_ctrl
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              INSTR_BYTES  = 4,
    parameter int              IALIGN       = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            branch_en,
    input  logic            take_branch,
    input  logic            jump_en,
    input  logic            jalr,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] imm,
    input  logic            trap_en,
    input  logic [XLEN-1:0] trap_vector,
    output logic            if_valid,
    output logic [XLEN-1:0] if_addr,
    input  logic            if_ready,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc_plus4,
    output logic            redirect_flush,
    output logic            misalign_exc,
    output logic [XLEN-1:0] misalign_addr
);

    localparam logic [XLEN-1:0] c_STEP = XLEN'(INSTR_BYTES);

    state_e          r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_held;
    logic            r_pend_valid;
    logic [XLEN-1:0] r_pend_addr;

    logic [XLEN-1:0] w_target;
    redirect_e       w_cause;
    logic            w_misaligned;
    logic            w_accept;
    logic            w_redirect;
    logic            w_hold_now;

    pc_target_calc #(
        .XLEN   (XLEN),
        .IALIGN (IALIGN)
    ) u_target_calc (
        .branch_en   (branch_en),
        .take_branch (take_branch),
        .jump_en     (jump_en),
        .jalr        (jalr),
        .ex_pc       (ex_pc),
        .rs1         (rs1),
        .imm         (imm),
        .trap_en     (trap_en),
        .trap_vector (trap_vector),
        .target      (w_target),
        .cause       (w_cause),
        .misaligned  (w_misaligned)
    );

    assign if_valid   = (r_state == REQ) && (!stall || r_held);
    assign if_addr    = r_pc;
    assign w_accept   = if_valid && if_ready;
    assign w_redirect = (w_cause != RD_NONE) && !w_misaligned;
    // An offered-but-unaccepted request must keep its address, so redirects park.
    assign w_hold_now = r_held || (if_valid && !if_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_pc           <= RESET_VECTOR;
            r_held         <= 1'b0;
            r_pend_valid   <= 1'b0;
            r_pend_addr    <= '0;
            id_valid       <= 1'b0;
            id_pc          <= '0;
            id_pc_plus4    <= '0;
            redirect_flush <= 1'b0;
            misalign_exc   <= 1'b0;
            misalign_addr  <= '0;
        end else begin
            r_state        <= REQ;
            redirect_flush <= w_redirect;
            misalign_exc   <= w_misaligned;
            if (w_misaligned) begin
                misalign_addr <= w_target;
            end

            if (w_accept) begin
                r_held       <= 1'b0;
                r_pend_valid <= 1'b0;
                id_pc        <= r_pc;
                id_pc_plus4  <= r_pc + c_STEP;
                id_valid     <= !(r_pend_valid || w_redirect);
                if (w_redirect) begin
                    r_pc <= w_target;
                end else if (r_pend_valid) begin
                    r_pc <= r_pend_addr;
                end else begin
                    r_pc <= r_pc + c_STEP;
                end
            end else begin
                id_valid <= 1'b0;
                if (if_valid) begin
                    r_held <= 1'b1;
                end
                if (w_redirect) begin
                    if (w_hold_now) begin
                        r_pend_valid <= 1'b1;
                        r_pend_addr  <= w_target;
                    end else begin
                        r_pc <= w_target;
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire
